// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax block: collector FSM states,
// vector length and arithmetic-format selectors.
package softmax_pkg;

    localparam int unsigned SOFTMAX_VEC_LEN  = 4;
    localparam int unsigned COUNT_W          = $clog2(SOFTMAX_VEC_LEN);

    localparam int unsigned ARITH_TYPE_FIXED = 1;
    localparam int unsigned ARITH_TYPE_FLOAT = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        BUSY    = 1'b1
    } collect_state_e;

endpackage

// File: rtl/softmax_max_compare.sv
// Combinational strict greater-than for either two's-complement fixed-point
// or sign-magnitude float words; shared by every max stage of the softmax block.
module softmax_max_compare
    import softmax_pkg::*;
#(
    parameter int unsigned ARITH_TYPE = ARITH_TYPE_FIXED,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned E          = 8,
    parameter int unsigned M          = 23
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int unsigned MAG_W = E + M;

    logic             sign_a;
    logic             sign_b;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             fixed_gt;
    logic             float_gt;

    assign sign_a   = a[DATA_WIDTH-1];
    assign sign_b   = b[DATA_WIDTH-1];
    assign mag_a    = a[MAG_W-1:0];
    assign mag_b    = b[MAG_W-1:0];
    assign fixed_gt = $signed(a) > $signed(b);

    // Float ordering on sign/magnitude; +0 and -0 are treated as equal.
    always_comb begin
        float_gt = 1'b0;
        if (mag_a == '0 && mag_b == '0) begin
            float_gt = 1'b0;
        end else if (!sign_a && !sign_b) begin
            float_gt = mag_a > mag_b;
        end else if (sign_a != sign_b) begin
            float_gt = !sign_a;
        end else begin
            float_gt = mag_a < mag_b;
        end
    end

    assign a_gt_b = (ARITH_TYPE == ARITH_TYPE_FIXED) ? fixed_gt : float_gt;

endmodule

// File: rtl/softmax_input_collector.sv
// Packs a serial score stream into groups of four with a running maximum and
// holds each vector for the softmax stage until it reports completion.
module softmax_input_collector
    import softmax_pkg::*;
#(
    parameter int unsigned ARITH_TYPE = ARITH_TYPE_FIXED,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INTEGER    = 10,
    parameter int unsigned FRACTION   = 22,
    parameter int unsigned E          = 8,
    parameter int unsigned M          = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] in4,
    output logic [DATA_WIDTH-1:0] max_input,
    output logic                  softmax_enable,
    input  logic                  softmax_output_ready
);

    // Elaboration-time consistency of the word formats.
    if (E + M + 1 != DATA_WIDTH) begin : g_bad_float_fmt
        $error("softmax_input_collector: E+M+1 must equal DATA_WIDTH");
    end
    if (ARITH_TYPE == ARITH_TYPE_FIXED && INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_fixed_fmt
        $error("softmax_input_collector: INTEGER+FRACTION must equal DATA_WIDTH");
    end

    collect_state_e        state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] slot_q [SOFTMAX_VEC_LEN];
    logic [DATA_WIDTH-1:0] slot_d [SOFTMAX_VEC_LEN];
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  enable_q, enable_d;
    logic                  beat;
    logic                  data_gt_max;

    softmax_max_compare #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH),
        .E          (E),
        .M          (M)
    ) u_max_compare (
        .a      (data_in),
        .b      (max_q),
        .a_gt_b (data_gt_max)
    );

    assign data_ready = (state_q == COLLECT);
    assign beat       = data_valid && data_ready;

    // Next-state and datapath decode; everything holds unless a beat or release occurs.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        slot_d   = slot_q;
        max_d    = max_q;
        enable_d = enable_q;
        case (state_q)
            COLLECT: begin
                if (beat) begin
                    slot_d[count_q] = data_in;
                    if (count_q == '0 || data_gt_max) begin
                        max_d = data_in;
                    end
                    if (count_q == COUNT_W'(SOFTMAX_VEC_LEN - 1)) begin
                        count_d  = '0;
                        state_d  = BUSY;
                        enable_d = 1'b1;
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (softmax_output_ready) begin
                    state_d  = COLLECT;
                    enable_d = 1'b0;
                end
            end
            default: begin
                state_d  = COLLECT;
                count_d  = '0;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            max_q    <= '0;
            enable_q <= 1'b0;
            for (int i = 0; i < SOFTMAX_VEC_LEN; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            max_q    <= max_d;
            enable_q <= enable_d;
            slot_q   <= slot_d;
        end
    end

    assign in1            = slot_q[0];
    assign in2            = slot_q[1];
    assign in3            = slot_q[2];
    assign in4            = slot_q[3];
    assign max_input      = max_q;
    assign softmax_enable = enable_q;

endmodule

// File: tb/tb_softmax_input_collector.sv
// Drives one stream into a fixed-point and a float collector side by side and
// checks every cycle against a queue-based reference of the grouping rules.
module tb_softmax_input_collector;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          softmax_output_ready;

    logic          fx_ready, fx_en, fl_ready, fl_en;
    logic [DW-1:0] fx_in1, fx_in2, fx_in3, fx_in4, fx_max;
    logic [DW-1:0] fl_in1, fl_in2, fl_in3, fl_in4, fl_max;

    int n_checks = 0;
    int n_pass   = 0;

    softmax_input_collector #(.ARITH_TYPE(1)) dut_fx (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(fx_ready), .in1(fx_in1), .in2(fx_in2), .in3(fx_in3), .in4(fx_in4),
        .max_input(fx_max), .softmax_enable(fx_en),
        .softmax_output_ready(softmax_output_ready)
    );

    softmax_input_collector #(.ARITH_TYPE(0)) dut_fl (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(fl_ready), .in1(fl_in1), .in2(fl_in2), .in3(fl_in3), .in4(fl_in4),
        .max_input(fl_max), .softmax_enable(fl_en),
        .softmax_output_ready(softmax_output_ready)
    );

    always #5 clk = ~clk;

    // Reference: whether a vector is pending, the slot contents and the current group so far.
    bit            m_busy;
    bit            m_en;
    logic [DW-1:0] m_slot [4];
    logic [DW-1:0] grp [$];
    logic [DW-1:0] m_max_fx, m_max_fl;

    function automatic longint float_key(input logic [DW-1:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? -mag : mag;
    endfunction

    function automatic longint fixed_key(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // First element wins ties: only a strictly larger later value replaces it.
    function automatic logic [DW-1:0] grp_max(input bit is_float);
        logic [DW-1:0] best;
        best = grp[0];
        for (int i = 1; i < grp.size(); i++) begin
            if (is_float ? (float_key(grp[i]) > float_key(best))
                         : (fixed_key(grp[i]) > fixed_key(best)))
                best = grp[i];
        end
        return best;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_all();
        check("fx_ready", DW'(fx_ready), DW'(!m_busy));
        check("fl_ready", DW'(fl_ready), DW'(!m_busy));
        check("fx_en",    DW'(fx_en),    DW'(m_en));
        check("fl_en",    DW'(fl_en),    DW'(m_en));
        check("fx_in1", fx_in1, m_slot[0]);
        check("fx_in2", fx_in2, m_slot[1]);
        check("fx_in3", fx_in3, m_slot[2]);
        check("fx_in4", fx_in4, m_slot[3]);
        check("fl_in1", fl_in1, m_slot[0]);
        check("fl_in2", fl_in2, m_slot[1]);
        check("fl_in3", fl_in3, m_slot[2]);
        check("fl_in4", fl_in4, m_slot[3]);
        check("fx_max", fx_max, m_max_fx);
        check("fl_max", fl_max, m_max_fl);
    endtask

    // One clock: advance the reference with the inputs present at the edge, then compare.
    task automatic tick();
        bit            rst, acc, rel;
        logic [DW-1:0] d;
        rst = reset;
        acc = data_valid && !m_busy;
        rel = softmax_output_ready && m_busy;
        d   = data_in;
        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = 0; m_en = 0; grp.delete();
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
            m_max_fx = '0; m_max_fl = '0;
        end else if (rel) begin
            m_busy = 0; m_en = 0;
        end else if (acc) begin
            m_slot[grp.size()] = d;
            grp.push_back(d);
            m_max_fx = grp_max(0);
            m_max_fl = grp_max(1);
            if (grp.size() == 4) begin
                grp.delete();
                m_busy = 1; m_en = 1;
            end
        end
        check_all();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        data_valid = v; data_in = d; softmax_output_ready = r;
        tick();
    endtask

    task automatic group4(input logic [DW-1:0] a, b, c, e);
        drive(1, a, 0); drive(1, b, 0); drive(1, c, 0); drive(1, e, 0);
    endtask

    task automatic release_vec();
        drive(0, '0, 0);
        drive(0, '0, 1);
    endtask

    logic [DW-1:0] pool [8];

    initial begin
        pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h3F800000;
        pool[3] = 32'hBF800000; pool[4] = 32'hFFC00000; pool[5] = 32'h00E00000;
        pool[6] = 32'h7F800000; pool[7] = 32'hFF800000;

        reset = 1; data_valid = 0; data_in = '0; softmax_output_ready = 0;
        tick(); tick();
        reset = 0;
        drive(0, '0, 0);

        // Fixed ordered group.
        group4(32'h00400000, 32'hFF800000, 32'h00E00000, 32'h00200000);
        check("t1_fx_max_const", fx_max, 32'h00E00000);
        release_vec();

        // All negative with a tie.
        group4(32'hFF800000, 32'hFFC00000, 32'hFFC00000, 32'hFF000000);
        check("t2_fx_max_const", fx_max, 32'hFFC00000);
        release_vec();

        // Float signed zeros and ordinary values.
        group4(32'hC0000000, 32'h80000000, 32'h00000000, 32'hBF800000);
        check("t3a_fl_max_const", fl_max, 32'h80000000);
        release_vec();
        group4(32'h3F800000, 32'h40600000, 32'h3F000000, 32'hC0000000);
        check("t3b_fl_max_const", fl_max, 32'h40600000);

        // Hold the vector while the source keeps offering data.
        for (int i = 0; i < 10; i++) drive(1, (i % 2) ? 32'h12345678 : 32'h00ABCDEF, 0);
        drive(1, 32'h01000000, 1);
        drive(1, 32'h01000000, 0);
        check("t4_first_beat_after_release", fx_in1, 32'h01000000);
        drive(1, 32'h00100000, 0); drive(1, 32'hF0000000, 0); drive(1, 32'h02000000, 0);
        release_vec();

        // Gapped valid pattern 1,0,0,1,1,0,1.
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int i = 0; i < 7; i++) drive(pat[i], $urandom, 0);
        end
        drive(0, '0, 0);
        release_vec();

        // Reset after two beats, then a fresh group.
        drive(1, 32'h05000000, 0); drive(1, 32'h06000000, 0);
        reset = 1; drive(0, '0, 0); reset = 0;
        group4(32'hFFF00000, 32'h00001000, 32'h80000001, 32'h00000FFF);
        // Reset while the vector is pending, then a fresh group.
        drive(0, '0, 0);
        reset = 1; drive(1, 32'h11111111, 0); reset = 0;
        group4(32'hBF800000, 32'hC0000000, 32'h3F000000, 32'h00000000);
        release_vec();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : DW'($urandom),
                  $urandom_range(0, 9) < 3);
        end
        reset = 0;
        drive(0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/softmax_input_collector.md
Name: softmax_input_collector

Overview:
- Upstream stage of the softmax block.
- Accepts a serial stream of scores, one per accepted beat, and packs each group of four into in1..in4.
- Tracks the running maximum of each group as it arrives.
- Drives max_input and softmax_enable into softmax, then holds everything stable until softmax reports softmax_output_ready.
- Supports both fixed-point (QINTEGER.FRACTION two's complement) and floating-point (E/M sign-magnitude) formats, selected by ARITH_TYPE.

Parameters:
- ARITH_TYPE, 1, 1 = fixed-point signed compare; 0 = floating-point compare.
- DATA_WIDTH, 32, width of every data word.
- INTEGER, 10, fixed-point integer bits (informational; compare is full-width signed).
- FRACTION, 22, fixed-point fraction bits (informational).
- E, 8, float exponent bits.
- M, 23, float mantissa bits; E+M+1 must equal DATA_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  incoming score.
- data_valid  input  1  data_in valid.
- data_ready  output  1  collector can accept; a beat transfers when data_valid && data_ready.
- in1, in2, in3, in4  output  DATA_WIDTH each  collected scores, in arrival order.
- max_input  output  DATA_WIDTH  maximum of in1..in4.
- softmax_enable  output  1  vector valid and softmax requested; level signal.
- softmax_output_ready  input  1  softmax done; releases the vector.

Behaviour:
- All state is registered. All outputs are driven from flops, except data_ready, which is decoded directly from the state register.
- Reset (synchronous, and honoured in any state, including mid-group or while BUSY):
  - state = COLLECT, count = 0.
  - in1..in4 = 0, max_input = 0, softmax_enable = 0.
  - data_ready = 1 from the first cycle after reset.
  - A partially collected group is discarded.
- FSM states: COLLECT, BUSY.
- COLLECT:
  - data_ready = 1.
  - On each accepted beat, data_in is written into slot[count] (count 0 -> in1 ... 3 -> in4) and count increments.
  - count = 0: max_input loads data_in unconditionally.
  - count > 0: max_input updates only if data_in is strictly greater than the current max. Ties keep the earlier value, so max_input bits are always an exact copy of one slot.
  - Accepting the 4th beat (count = 3): count wraps to 0, state -> BUSY, and softmax_enable = 1 in the next cycle.
  - Latency: 4th beat accepted at edge N -> in1..in4, max_input and softmax_enable are all valid at edge N+1.
  - softmax_output_ready is ignored in COLLECT.
- BUSY:
  - data_ready = 0; in1..in4 and max_input are held stable; softmax_enable stays 1.
  - If softmax_output_ready = 1 at edge K: softmax_enable = 0 and state = COLLECT after edge K, with data_ready = 1 in the same cycle.
  - The first beat of the next group can therefore be accepted at edge K+1.
  - in1..in4 and max_input keep their old values until they are overwritten by new beats.
- data_valid while data_ready = 0 is not a transfer. The source must hold data_in; no beat is lost or duplicated.
- Fixed compare (ARITH_TYPE = 1): signed greater-than on the full DATA_WIDTH.
- Float compare (ARITH_TYPE = 0):
  - Both non-negative: a > b iff magnitude a > magnitude b.
  - Signs differ: the positive operand wins.
  - Both negative: a > b iff magnitude a < magnitude b.
  - +0 and -0 compare equal (no update).
  - NaN and Inf get no special handling; they are ordered by these rules.

Decomposition:
- softmax_pkg:
  - State enum (COLLECT, BUSY).
  - Localparam SOFTMAX_VEC_LEN = 4 and the count width.
  - ARITH_TYPE_FIXED = 1, ARITH_TYPE_FLOAT = 0.
- Sub-module softmax_max_compare (parameters ARITH_TYPE, DATA_WIDTH, E, M):
  - Combinational; inputs a, b; output a_gt_b implementing the rules above.
  - Reused later by any max-tree stage.

Test Plan:
1. Fixed, ordered input. Beats 0x00400000 (1.0), 0xFF800000 (-2.0), 0x00E00000 (3.5), 0x00200000 (0.5) on consecutive cycles.
   -> in1..in4 in that order, max_input = 0x00E00000, softmax_enable high one cycle after the 4th beat, data_ready = 0.
2. Fixed, all negative with a tie. Beats 0xFF800000, 0xFFC00000, 0xFFC00000, 0xFF000000.
   -> max_input = 0xFFC00000 (-1.0), and the tie does not change the selected value.
3. Float. ARITH_TYPE = 0; beats 0xC0000000 (-2.0), 0x80000000 (-0), 0x00000000 (+0), 0xBF800000 (-1.0).
   -> max_input = 0x80000000 (first zero kept); beats 0x3F800000, 0x40600000, 0x3F000000, 0xC0000000 -> max_input = 0x40600000.
4. Handshake. Hold softmax_output_ready = 0 for 10 cycles while BUSY, with data_valid = 1 and data_in toggling.
   -> no beat accepted, outputs stable. Pulse softmax_output_ready at edge K -> softmax_enable = 0 and data_ready = 1 after K; the next group's first beat is accepted at K+1.
5. Gapped input. Deassert data_valid between beats (pattern 1,0,0,1,1,0,1).
   -> exactly 4 beats captured in order; enable asserts one cycle after the last accepted beat.
6. Reset mid-operation. Assert reset after 2 beats, and separately while BUSY.
   -> next cycle all outputs 0, softmax_enable = 0, data_ready = 1. The following 4 beats form a fresh group with a correct max.
